pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Next-generation program counter generator for the MIPS fetch stage.
- Holds the architectural fetch PC in a register and advances it on a fetch handshake.
- Applies branch/jump redirects with MIPS delay-slot semantics, exception redirects, and ERET returns.
- Sits between the ID/EX redirect sources and the instruction-fetch/SRAM request logic; replaces the fixed +4 combinational incrementer.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_PC, 32'h80000000, first fetch address after reset.
- EXC_VECTOR, 32'h80000380, exception entry address.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_ready  in  1  fetch accepts current pc this cycle
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc is a valid fetch request
- br_valid  in  1  taken branch/jump resolved in ID; current pc is its delay slot
- br_target  in  ADDR_W  branch/jump target
- exc_valid  in  1  exception flush request
- eret_valid  in  1  ERET flush request
- epc  in  ADDR_W  ERET return address
- pc_misalign  out  1  pc[1:0] != 0 while pc_valid
- redir_pending  out  1  a branch target is held awaiting delay-slot fetch

Behaviour:
- Reset: pc=RESET_PC, pc_valid=0, redir_pending=0, state=SEQ. The first cycle after rst deasserts: pc_valid=1, pc=RESET_PC. rst mid-operation discards any pending redirect.
- Handshake: fire = pc_valid & if_ready. pc changes only on fire or on a flush. While !if_ready, pc and pc_valid hold stable.
- Priority, highest first: exc_valid > eret_valid > br_valid > sequential.
- exc_valid: next cycle pc=EXC_VECTOR, pc_valid=1, state=SEQ, pending target dropped. This is independent of if_ready.
- eret_valid (no exc): same as exc_valid but with pc=epc.
- States SEQ, PEND.
- SEQ, no flush, br_valid & fire: the delay slot (current pc) is accepted. Next pc=br_target, stay SEQ.
- SEQ, no flush, br_valid & !fire: latch br_target, go to PEND, redir_pending=1.
- SEQ, no flush, !br_valid & fire: pc=pc+INC.
- PEND: br_valid is ignored (illegal; a branch cannot sit in a delay slot). On fire: pc=latched target, state=SEQ, redir_pending=0. Without fire: hold.
- Arithmetic: pc+INC truncates to ADDR_W. Wrap from 32'hFFFFFFFC gives 32'h00000000, with no flag.
- Targets are not realigned. pc_misalign is combinational from pc[1:0] gated by pc_valid; the fetch stage raises AdEL.
- Latency: redirect to the pc output is 1 cycle after the qualifying edge.

Optional Feature:
- Macro: PCG_PERF_EN.
- Defined: adds output redir_cnt [31:0]. It resets to 0 and increments by 1 on each cycle where exc_valid, eret_valid, or (a branch target is applied to pc). It wraps at 2^32.
- Not defined: redir_cnt port is absent and no counter logic is generated.

Test Plan:
- Reset release, if_ready=1 for 3 cycles -> pc sequence 80000000, 80000004, 80000008; pc_valid=0 during rst.
- At pc=80000010: br_valid=1, br_target=80000100, if_ready=1 -> next pc 80000100, redir_pending never 1.
- At pc=80000010: br_valid=1, br_target=80000200, if_ready=0 for 2 cycles -> pc holds 80000010, redir_pending=1. When if_ready=1 -> pc=80000200, redir_pending=0.
- In PEND with target 80000200: exc_valid=1 and eret_valid=1 in the same cycle -> pc=80000380, pending dropped. With PCG_PERF_EN, redir_cnt increments by exactly 1.
- br_target=80000102 applied -> pc=80000102, pc_misalign=1. Then eret_valid=1, epc=80000040 -> pc=80000040, pc_misalign=0.
- Force pc to FFFFFFFC via eret, fire -> pc=00000000. Assert rst in PEND -> pc=80000000, redir_pending=0.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: sequential advance, delay-slot branch redirect, exception/ERET flush.
// Optional redirect counter port redir_cnt is built when PCG_PERF_EN is defined.
module pc_gen_unit #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h80000380,
    parameter int INC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic              pc_misalign,
`ifdef PCG_PERF_EN
    output logic [31:0]       redir_cnt,
`endif
    output logic              redir_pending
);

    typedef enum logic {SEQ, PEND} state_t;

    state_t            state;
    logic [ADDR_W-1:0] tgt;
    logic              fire;

    assign fire        = pc_valid & if_ready;
    assign pc_misalign = pc_valid & (pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            pc_valid      <= 1'b0;
            state         <= SEQ;
            redir_pending <= 1'b0;
            tgt           <= '0;
        end else begin
            pc_valid <= 1'b1;
            if (exc_valid) begin
                pc            <= EXC_VECTOR;
                state         <= SEQ;
                redir_pending <= 1'b0;
            end else if (eret_valid) begin
                pc            <= epc;
                state         <= SEQ;
                redir_pending <= 1'b0;
            end else begin
                case (state)
                    SEQ: begin
                        // Current pc is the delay slot; target waits until it is accepted.
                        if (br_valid) begin
                            if (fire) begin
                                pc <= br_target;
                            end else begin
                                tgt           <= br_target;
                                state         <= PEND;
                                redir_pending <= 1'b1;
                            end
                        end else if (fire) begin
                            pc <= pc + ADDR_W'(INC);
                        end
                    end
                    PEND: begin
                        if (fire) begin
                            pc            <= tgt;
                            state         <= SEQ;
                            redir_pending <= 1'b0;
                        end
                    end
                    default: state <= SEQ;
                endcase
            end
        end
    end

`ifdef PCG_PERF_EN
    logic br_apply;

    assign br_apply = fire & ((state == SEQ & br_valid) | (state == PEND));

    always_ff @(posedge clk) begin
        if (rst)
            redir_cnt <= '0;
        else if (exc_valid | eret_valid | br_apply)
            redir_cnt <= redir_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Randomized and directed check of pc_gen_unit against a behavioural fetch-PC model.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst, if_ready, br_valid, exc_valid, eret_valid;
    logic [31:0] br_target, epc, pc;
    logic        pc_valid, pc_misalign, redir_pending;
`ifdef PCG_PERF_EN
    logic [31:0] redir_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_pend[$];
    logic [31:0] m_cnt;

    pc_gen_unit dut (
        .clk          (clk),
        .rst          (rst),
        .if_ready     (if_ready),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .exc_valid    (exc_valid),
        .eret_valid   (eret_valid),
        .epc          (epc),
        .pc_misalign  (pc_misalign),
`ifdef PCG_PERF_EN
        .redir_cnt    (redir_cnt),
`endif
        .redir_pending(redir_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit fire;
        fire = m_valid && if_ready;
        if (rst) begin
            m_pc    = 32'h80000000;
            m_valid = 1'b0;
            m_pend  = {};
            m_cnt   = 0;
            return;
        end
        if (exc_valid || eret_valid) begin
            m_pc   = exc_valid ? 32'h80000380 : epc;
            m_pend = {};
            m_cnt++;
        end else if (m_pend.size() != 0) begin
            if (fire) begin
                m_pc = m_pend.pop_front();
                m_cnt++;
            end
        end else if (br_valid) begin
            if (fire) begin
                m_pc = br_target;
                m_cnt++;
            end else begin
                m_pend.push_back(br_target);
            end
        end else if (fire) begin
            m_pc = m_pc + 32'd4;
        end
        m_valid = 1'b1;
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic b,
                       input logic [31:0] t, input logic e, input logic er,
                       input logic [31:0] ep);
        rst = r; if_ready = rdy; br_valid = b; br_target = t;
        exc_valid = e; eret_valid = er; epc = ep;
        model_step();
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_valid", 32'(pc_valid), 32'(m_valid));
        chk("pending", 32'(redir_pending), 32'(m_pend.size() != 0));
        chk("misalign", 32'(pc_misalign),
            32'(m_valid && (m_pc[1:0] != 2'b00)));
`ifdef PCG_PERF_EN
        chk("redir_cnt", redir_cnt, m_cnt);
`endif
    endtask

    task automatic set_pc(input logic [31:0] a);
        cyc(0, 0, 0, 0, 0, 1, a);
    endtask

    initial begin
        m_pc = 0; m_valid = 0; m_cnt = 0;
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("first_pc", pc, 32'h80000000);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("seq1", pc, 32'h80000004);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("seq2", pc, 32'h80000008);

        set_pc(32'h80000010);
        cyc(0, 1, 1, 32'h80000100, 0, 0, 0);
        chk("br_fire", pc, 32'h80000100);

        set_pc(32'h80000010);
        cyc(0, 0, 1, 32'h80000200, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("pend_hold", pc, 32'h80000010);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("pend_apply", pc, 32'h80000200);

        set_pc(32'h80000010);
        cyc(0, 0, 1, 32'h80000200, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h80000040);
        chk("exc_vec", pc, 32'h80000380);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("exc_drop", pc, 32'h80000384);

        cyc(0, 1, 1, 32'h80000102, 0, 0, 0);
        chk("mis_on", 32'(pc_misalign), 32'd1);
        cyc(0, 1, 0, 0, 0, 1, 32'h80000040);
        chk("eret_pc", pc, 32'h80000040);

        set_pc(32'hFFFFFFFC);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("wrap", pc, 32'h00000000);

        cyc(0, 0, 1, 32'h80000200, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("rst_pc", pc, 32'h80000000);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rst_drop", pc, 32'h80000004);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] t, ep;
            t  = $urandom;
            ep = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(3) != 0) ep[1:0] = 2'b00;
            cyc($urandom_range(49) == 0, $urandom_range(2) != 0,
                $urandom_range(3) == 0, t,
                $urandom_range(19) == 0, $urandom_range(14) == 0, ep);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
